dcache_ctrl: RTL and testbench

Direct-mapped, write-through data cache controller between the single-cycle core's data-memory port and a slow, handshaked backing memory. It serves read hits combinationally in the same cycle. On a read miss it stalls the core and refills a 4-word line by sequential word requests. Writes go straight to backing memory (write-through, no write-allocate), and the cached copy is updated when the write hits.

---
 rtl/dcache_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through D-cache with sequential 4-word refill, no write-allocate; optional DCACHE_STATS_EN adds hit/miss counters.
// Latency: read hit 0 cycles; read miss 1 + sum of per-word ack waits + 1 lookup cycle; store IDLE + WRITE(>=1) + WDONE.
// Backpressure: Stall holds the core while a backing request is outstanding; Mem_req stays high until Mem_ack.
module dcache_ctrl #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Read_data,
    output logic        Stall,
    output logic        Mem_req,
    output logic        Mem_we,
    output logic [31:0] Mem_addr,
    output logic [31:0] Mem_wdata,
    input  logic [31:0] Mem_rdata,
    input  logic        Mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] Hit_count,
    output logic [31:0] Miss_count
`endif
);
    localparam int INDEX_BITS = $clog2(LINES);
    localparam int OFF_BITS   = $clog2(WORDS);
    localparam int TAG_BITS   = 28 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;

    state_t state, next_state;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES][WORDS];

    logic [OFF_BITS-1:0] cnt;
    logic [31:2]         lat_addr;

    // Lookup fields of the live core address
    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] idx;
    logic [OFF_BITS-1:0]   off;
    logic                  hit;

    // Same fields of the latched address for the transaction in flight
    logic [TAG_BITS-1:0]   lat_tag;
    logic [INDEX_BITS-1:0] lat_idx;
    logic [OFF_BITS-1:0]   lat_off;
    logic                  lat_hit;

    logic unused_byte_bits;

    assign tag = Address[31:4+INDEX_BITS];
    assign idx = Address[3+INDEX_BITS:4];
    assign off = Address[3:2];
    assign hit = valid[idx] && (tag_mem[idx] == tag);

    assign lat_tag = lat_addr[31:4+INDEX_BITS];
    assign lat_idx = lat_addr[3+INDEX_BITS:4];
    assign lat_off = lat_addr[3:2];
    assign lat_hit = valid[lat_idx] && (tag_mem[lat_idx] == lat_tag);

    assign unused_byte_bits = ^Address[1:0];

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= next_state;
    end

    // Next state, stall and hit read data
    always_comb begin
        next_state = state;
        Stall      = 1'b0;
        Read_data  = '0;
        case (state)
            IDLE: begin
                if (MemWrite) begin
                    Stall      = 1'b1;
                    next_state = WRITE;
                end else if (MemRead) begin
                    if (hit) begin
                        Read_data = data_mem[idx][off];
                    end else begin
                        Stall      = 1'b1;
                        next_state = REFILL;
                    end
                end
            end
            REFILL: begin
                Stall = 1'b1;
                if (Mem_ack && cnt == 2'd3) next_state = IDLE;
            end
            WRITE: begin
                Stall = 1'b1;
                if (Mem_ack) next_state = WDONE;
            end
            WDONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Backing-memory request registers, word counter and valid bits
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid     <= '0;
            cnt       <= '0;
            lat_addr  <= '0;
            Mem_req   <= 1'b0;
            Mem_we    <= 1'b0;
            Mem_addr  <= '0;
            Mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MemWrite) begin
                        lat_addr  <= Address[31:2];
                        Mem_req   <= 1'b1;
                        Mem_we    <= 1'b1;
                        Mem_addr  <= {Address[31:2], 2'b00};
                        Mem_wdata <= Write_data;
                    end else if (MemRead && !hit) begin
                        // Line is rewritten word by word, so drop it until the fill completes
                        valid[idx] <= 1'b0;
                        lat_addr   <= Address[31:2];
                        cnt        <= '0;
                        Mem_req    <= 1'b1;
                        Mem_we     <= 1'b0;
                        Mem_addr   <= {Address[31:4], 4'b0000};
                    end
                end
                REFILL: begin
                    if (Mem_ack) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            valid[lat_idx] <= 1'b1;
                            Mem_req        <= 1'b0;
                        end else begin
                            Mem_addr <= {lat_addr[31:4], cnt + 2'd1, 2'b00};
                        end
                    end
                end
                WRITE: begin
                    if (Mem_ack) Mem_req <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays: refill words, final tag, write-hit update
    always_ff @(posedge CLK) begin
        if (state == REFILL && Mem_ack) begin
            data_mem[lat_idx][cnt] <= Mem_rdata;
            if (cnt == 2'd3) tag_mem[lat_idx] <= lat_tag;
        end
        if (state == WRITE && Mem_ack && lat_hit) begin
            data_mem[lat_idx][lat_off] <= Mem_wdata;
        end
    end

`ifdef DCACHE_STATS_EN
    // Load hit and refill-start counters; stores are not counted
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Hit_count  <= '0;
            Miss_count <= '0;
        end else if (state == IDLE && MemRead && !MemWrite) begin
            if (hit) Hit_count  <= Hit_count + 32'd1;
            else     Miss_count <= Miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a backing memory that acks 3 cycles into each request.
// Latency: n/a (testbench).
// Backpressure: the memory model holds Mem_ack for exactly one cycle per request.
module tb_dcache_ctrl;
    logic        CLK;
    logic        RESET;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Read_data;
    logic        Stall;
    logic        Mem_req;
    logic        Mem_we;
    logic [31:0] Mem_addr;
    logic [31:0] Mem_wdata;
    logic [31:0] Mem_rdata;
    logic        Mem_ack;
`ifdef DCACHE_STATS_EN
    logic [31:0] Hit_count;
    logic [31:0] Miss_count;
`endif

    dcache_ctrl #(.LINES(16), .WORDS(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Read_data  (Read_data),
        .Stall      (Stall),
        .Mem_req    (Mem_req),
        .Mem_we     (Mem_we),
        .Mem_addr   (Mem_addr),
        .Mem_wdata  (Mem_wdata),
        .Mem_rdata  (Mem_rdata),
        .Mem_ack    (Mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .Hit_count  (Hit_count),
        .Miss_count (Miss_count)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] bmem [logic [31:0]];
    logic [31:0] log_addr [$];
    logic        log_we   [$];
    logic [31:0] log_dat  [$];
    int          wcnt;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Untouched backing words hold {addr[15:0]^16'h5A5A, addr[15:0]}
    function automatic logic [31:0] bmem_rd(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Backing memory: ack in the third cycle of each request, log every completed request
    always @(negedge CLK or negedge RESET) begin
        if (!RESET) begin
            Mem_ack = 1'b0;
            wcnt    = 0;
        end else if (!Mem_req) begin
            Mem_ack = 1'b0;
            wcnt    = 0;
        end else begin
            wcnt = wcnt + 1;
            if (wcnt == 3) begin
                wcnt = 0;
                Mem_ack = 1'b1;
                log_addr.push_back(Mem_addr);
                log_we.push_back(Mem_we);
                log_dat.push_back(Mem_wdata);
                if (Mem_we) bmem[Mem_addr] = Mem_wdata;
                else        Mem_rdata = bmem_rd(Mem_addr);
            end else begin
                Mem_ack = 1'b0;
            end
        end
    end

    task automatic do_read(input logic [31:0] a, output int stalls, output logic [31:0] rd);
        @(negedge CLK);
        Address = a; MemRead = 1'b1; MemWrite = 1'b0;
        #1;
        stalls = 0;
        while (Stall && stalls < 200) begin
            @(negedge CLK); #1;
            stalls++;
        end
        rd = Read_data;
        @(negedge CLK);
        MemRead = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, output int stalls);
        @(negedge CLK);
        Address = a; Write_data = d; MemWrite = 1'b1; MemRead = 1'b0;
        #1;
        stalls = 0;
        while (Stall && stalls < 200) begin
            @(negedge CLK); #1;
            stalls++;
        end
        @(negedge CLK);
        MemWrite = 1'b0;
    endtask

    task automatic chk_stats(input string tag, input logic [31:0] hits, input logic [31:0] misses);
`ifdef DCACHE_STATS_EN
        chk({tag, "_hits"}, Hit_count, hits);
        chk({tag, "_misses"}, Miss_count, misses);
`else
        if (hits == 32'hFFFF_FFFF && misses == 32'hFFFF_FFFF) $display("stats %s", tag);
`endif
    endtask

    initial begin
        int          st;
        int          base;
        int          n;
        logic [31:0] rd;

        RESET = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Address = '0; Write_data = '0; Mem_rdata = '0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_stall",     32'(Stall), 32'd0);
        chk("rst_mem_req",   32'(Mem_req), 32'd0);
        chk("rst_mem_we",    32'(Mem_we), 32'd0);
        chk("rst_mem_addr",  Mem_addr, 32'h0);
        chk("rst_mem_wdata", Mem_wdata, 32'h0);
        chk("rst_read_data", Read_data, 32'h0);
        chk_stats("rst", 32'd0, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;

        // Cold miss: 1 detect cycle + 4 words x 3 cycles of stall
        do_read(32'h40, st, rd);
        chk("miss40_stall", 32'(st), 32'd13);
        chk("miss40_data", rd, 32'h5A1A_0040);
        chk("miss40_nreq", 32'(log_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            chk("miss40_addr", log_addr[i], 32'h40 + 32'(4 * i));
            chk("miss40_we", 32'(log_we[i]), 32'd0);
        end
        // The post-fill lookup cycle is itself a load hit
        chk_stats("miss40", 32'd1, 32'd1);

        // Hit in the freshly filled line
        base = log_addr.size();
        do_read(32'h44, st, rd);
        chk("hit44_stall", 32'(st), 32'd0);
        chk("hit44_data", rd, 32'h5A1E_0044);
        chk("hit44_noreq", 32'(log_addr.size() - base), 32'd0);
        chk_stats("hit44", 32'd2, 32'd1);

        // Store hit: one write request, WDONE does not reissue
        base = log_addr.size();
        do_write(32'h48, 32'hDEAD_BEEF, st);
        #1;
        chk("st48_stall", 32'(st), 32'd4);
        chk("st48_req_after", 32'(Mem_req), 32'd0);
        repeat (4) @(negedge CLK);
        chk("st48_nreq", 32'(log_addr.size() - base), 32'd1);
        if (log_addr.size() > base) begin
            chk("st48_addr", log_addr[base], 32'h48);
            chk("st48_we", 32'(log_we[base]), 32'd1);
            chk("st48_wdata", log_dat[base], 32'hDEAD_BEEF);
        end
        base = log_addr.size();
        do_read(32'h48, st, rd);
        chk("rd48_stall", 32'(st), 32'd0);
        chk("rd48_data", rd, 32'hDEAD_BEEF);
        chk("rd48_noreq", 32'(log_addr.size() - base), 32'd0);
        chk_stats("rd48", 32'd3, 32'd1);

        // Store miss: no allocate, so the next read of it refills
        base = log_addr.size();
        do_write(32'h200, 32'h1234_5678, st);
        chk("st200_stall", 32'(st), 32'd4);
        repeat (2) @(negedge CLK);
        chk("st200_nreq", 32'(log_addr.size() - base), 32'd1);
        base = log_addr.size();
        do_read(32'h200, st, rd);
        chk("rd200_stall", 32'(st), 32'd13);
        chk("rd200_data", rd, 32'h1234_5678);
        chk("rd200_nreq", 32'(log_addr.size() - base), 32'd4);
        chk_stats("rd200", 32'd4, 32'd2);

        // Index conflict: 0x140 evicts 0x40
        base = log_addr.size();
        do_read(32'h140, st, rd);
        chk("rd140_stall", 32'(st), 32'd13);
        chk("rd140_data", rd, 32'h5B1A_0140);
        for (int i = 0; i < 4 && base + i < log_addr.size(); i++)
            chk("rd140_addr", log_addr[base + i], 32'h140 + 32'(4 * i));
        do_read(32'h40, st, rd);
        chk("rd40_again_stall", 32'(st), 32'd13);
        chk("rd40_again_data", rd, 32'h5A1A_0040);
        do_read(32'h48, st, rd);
        chk("rd48_after_fill", rd, 32'hDEAD_BEEF);
        chk_stats("conflict", 32'd7, 32'd4);

        // Reset after the second refill ack aborts the fill
        base = log_addr.size();
        @(negedge CLK);
        Address = 32'h80; MemRead = 1'b1;
        n = 0;
        while (log_addr.size() < base + 2 && n < 100) begin
            @(negedge CLK); #1;
            n++;
        end
        @(posedge CLK); #1;
        RESET = 1'b0; MemRead = 1'b0;
        #1;
        chk("abort_acks", 32'(log_addr.size() - base), 32'd2);
        chk("abort_req", 32'(Mem_req), 32'd0);
        chk("abort_stall", 32'(Stall), 32'd0);
        chk_stats("abort", 32'd0, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        base = log_addr.size();
        do_read(32'h80, st, rd);
        chk("reread80_stall", 32'(st), 32'd13);
        chk("reread80_data", rd, 32'h5ADA_0080);
        chk("reread80_nreq", 32'(log_addr.size() - base), 32'd4);
        for (int i = 0; i < 4 && base + i < log_addr.size(); i++)
            chk("reread80_addr", log_addr[base + i], 32'h80 + 32'(4 * i));
        chk_stats("reread80", 32'd1, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
